// File: rtl/clk_period_meter.sv
// Clock period meter: synchronises sig_in and measures its rise-to-rise period
// and rise-to-fall high phase in clk cycles, reporting each result with a one-cycle strobe.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             overflow,
    output logic             armed
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_prev_r;
    logic                   s_sync_s;
    logic                   rise_s;
    logic                   fall_s;
    logic [CNT_W-1:0]       cnt_inc_s;

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       hi_shadow_r;
    logic                   ovf_pend_r;
    logic [CNT_W-1:0]       period_r;
    logic [CNT_W-1:0]       high_time_r;
    logic                   valid_r;
    logic                   overflow_r;
    logic                   armed_r;

    // Synchroniser chain plus the delayed copy used for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r   <= {SYNC_STAGES{1'b0}};
            s_prev_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], sig_in};
            s_prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Edge decode and saturating cycle-count increment
    always_comb begin
        s_sync_s = sync_r[SYNC_STAGES-1];
        rise_s   = s_sync_s & ~s_prev_r;
        fall_s   = ~s_sync_s & s_prev_r;
        if (cnt_r == CNT_MAX) begin
            cnt_inc_s = CNT_MAX;
        end else begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end
    end

    // Measurement FSM: first rise arms, every later rise publishes the finished period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            hi_shadow_r <= CNT_ZERO;
            ovf_pend_r  <= 1'b0;
            period_r    <= CNT_ZERO;
            high_time_r <= CNT_ZERO;
            valid_r     <= 1'b0;
            overflow_r  <= 1'b0;
            armed_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            if (!en) begin
                // Results are kept; only the in-flight measurement is abandoned
                state_r     <= ST_IDLE;
                armed_r     <= 1'b0;
                cnt_r       <= CNT_ZERO;
                hi_shadow_r <= CNT_ZERO;
                ovf_pend_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        hi_shadow_r <= CNT_ZERO;
                        ovf_pend_r  <= 1'b0;
                        if (rise_s) begin
                            state_r <= ST_MEASURE;
                            armed_r <= 1'b1;
                            cnt_r   <= CNT_ONE;
                        end else begin
                            armed_r <= 1'b0;
                            cnt_r   <= CNT_ZERO;
                        end
                    end
                    ST_MEASURE: begin
                        armed_r <= 1'b1;
                        if (rise_s) begin
                            period_r    <= cnt_r;
                            high_time_r <= hi_shadow_r;
                            overflow_r  <= ovf_pend_r;
                            valid_r     <= 1'b1;
                            cnt_r       <= CNT_ONE;
                            hi_shadow_r <= CNT_ZERO;
                            ovf_pend_r  <= 1'b0;
                        end else begin
                            cnt_r <= cnt_inc_s;
                            if (cnt_inc_s == CNT_MAX) begin
                                ovf_pend_r <= 1'b1;
                            end
                            if (fall_s) begin
                                hi_shadow_r <= cnt_r;
                            end
                        end
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        armed_r     <= 1'b0;
                        cnt_r       <= CNT_ZERO;
                        hi_shadow_r <= CNT_ZERO;
                        ovf_pend_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign period    = period_r;
    assign high_time = high_time_r;
    assign valid     = valid_r;
    assign overflow  = overflow_r;
    assign armed     = armed_r;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: waveforms are built as per-cycle bit streams and the
// expected strobes are derived from the signal's edges with plain arithmetic.
module tb_clk_period_meter;

    localparam int CNT_W = 4;
    localparam int SS    = 2;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             overflow;
    logic             armed;

    typedef struct packed {
        logic [31:0]      idx;
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
        logic             ovf;
    } ev_t;

    bit               sig_q[$];
    bit               en_q[$];
    ev_t              exp_q[$];
    ev_t              obs_q[$];
    bit               exp_arm[$];
    logic             arm_obs[$];
    logic [CNT_W-1:0] per_obs[$];
    int               tests = 0;
    int               fails = 0;

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .en(en), .sig_in(sig_in),
        .period(period), .high_time(high_time), .valid(valid),
        .overflow(overflow), .armed(armed)
    );

    always #5 clk = ~clk;

    task automatic clear_seq();
        sig_q.delete();
        en_q.delete();
    endtask

    task automatic add_const(bit v, int n, bit e);
        for (int c = 0; c < n; c++) begin
            sig_q.push_back(v);
            en_q.push_back(e);
        end
    endtask

    task automatic add_wave(int p, int h, int n);
        for (int c = 0; c < n; c++) begin
            sig_q.push_back((c % p) < h);
            en_q.push_back(1'b1);
        end
    endtask

    // Reference: a rise seen while enabled arms; the next rise closes a period.
    // The edge at stream index k is acted on SS+1 edges later with en of index k+SS.
    task automatic model_run();
        bit armed_m = 1'b0;
        bit prev    = 1'b0;
        int last    = 0;
        int fall    = -1;
        int n       = sig_q.size();
        exp_q.delete();
        exp_arm.delete();
        for (int k = 0; k < n; k++) begin
            bit e, r, f;
            e = (k + SS < n) ? en_q[k+SS] : 1'b0;
            r = sig_q[k] && !prev;
            f = !sig_q[k] && prev;
            prev = sig_q[k];
            if (!e) begin
                armed_m = 1'b0;
            end else if (r) begin
                if (armed_m && (k + SS + 1 < n)) begin
                    int p, h;
                    ev_t ev;
                    p = k - last;
                    h = (fall >= 0) ? fall - last : 0;
                    ev.idx = 32'(k + SS + 1);
                    ev.per = (p >= MAXV) ? CNT_W'(MAXV) : CNT_W'(p);
                    ev.hi  = (h >= MAXV) ? CNT_W'(MAXV) : CNT_W'(h);
                    ev.ovf = (p >= MAXV);
                    exp_q.push_back(ev);
                end
                armed_m = 1'b1;
                last    = k;
                fall    = -1;
            end else if (f && armed_m) begin
                fall = k;
            end
            exp_arm.push_back(armed_m);
        end
    endtask

    // Drives one stream element per clock and records strobes at the falling edge
    task automatic play();
        ev_t ev;
        obs_q.delete();
        arm_obs.delete();
        per_obs.delete();
        for (int j = 0; j < sig_q.size(); j++) begin
            @(posedge clk);
            #1;
            sig_in = sig_q[j];
            en     = en_q[j];
            @(negedge clk);
            if (valid === 1'b1) begin
                ev.idx = 32'(j);
                ev.per = period;
                ev.hi  = high_time;
                ev.ovf = overflow;
                obs_q.push_back(ev);
            end
            arm_obs.push_back(armed);
            per_obs.push_back(period);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sig_in = 1'b0;
        #1;
        tests++;
        if ({period, high_time, valid, overflow, armed} !== {(2*CNT_W+3){1'b0}}) begin
            fails++;
            $display("FAIL reset_state: got per=%0d hi=%0d v=%b o=%b a=%b, expected all 0",
                     period, high_time, valid, overflow, armed);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_seq();
        add_const(1'b0, 4, 1'b0);
        add_wave(4, 2, 30);
        model_run();
        play();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL prerst count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t o;
            o = (i < obs_q.size()) ? obs_q[i] : ev_t'(0);
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL prerst strobe %0d: got idx=%0d per=%0d hi=%0d ovf=%0b, expected idx=%0d per=%0d hi=%0d ovf=%0b",
                         i, o.idx, o.per, o.hi, o.ovf, exp_q[i].idx, exp_q[i].per, exp_q[i].hi, exp_q[i].ovf);
            end
        end
        #2;
        rst = 1'b1;
        sig_in = 1'b0;
        #1;
        tests++;
        if ({period, high_time, valid, overflow, armed} !== {(2*CNT_W+3){1'b0}}) begin
            fails++;
            $display("FAIL midrun_reset: got per=%0d hi=%0d v=%b o=%b a=%b, expected all 0",
                     period, high_time, valid, overflow, armed);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_seq();
        add_wave(5, 2, 30);
        add_const(1'b0, 5, 1'b0);
        model_run();
        play();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL postrst count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t o;
            o = (i < obs_q.size()) ? obs_q[i] : ev_t'(0);
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL postrst strobe %0d: got idx=%0d per=%0d hi=%0d ovf=%0b, expected idx=%0d per=%0d hi=%0d ovf=%0b",
                         i, o.idx, o.per, o.hi, o.ovf, exp_q[i].idx, exp_q[i].per, exp_q[i].hi, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_wave(string name, int p, int h, int nper);
        clear_seq();
        add_const(1'b0, 4, 1'b0);
        add_wave(p, h, p * nper);
        add_const(1'b0, 5, 1'b0);
        model_run();
        play();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL %s count: got %0d strobes, expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t o;
            o = (i < obs_q.size()) ? obs_q[i] : ev_t'(0);
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL %s strobe %0d: got idx=%0d per=%0d hi=%0d ovf=%0b, expected idx=%0d per=%0d hi=%0d ovf=%0b",
                         name, i, o.idx, o.per, o.hi, o.ovf, exp_q[i].idx, exp_q[i].per, exp_q[i].hi, exp_q[i].ovf);
            end
        end
        tests++;
        if (period !== exp_q[exp_q.size()-1].per) begin
            fails++;
            $display("FAIL %s held_period: got %0d, expected %0d", name, period, exp_q[exp_q.size()-1].per);
        end
    endtask

    task automatic test_saturate();
        clear_seq();
        add_const(1'b0, 4, 1'b0);
        add_wave(20, 10, 60);
        add_wave(6, 3, 24);
        add_const(1'b0, 5, 1'b0);
        model_run();
        play();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL saturate count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t o;
            o = (i < obs_q.size()) ? obs_q[i] : ev_t'(0);
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL saturate strobe %0d: got idx=%0d per=%0d hi=%0d ovf=%0b, expected idx=%0d per=%0d hi=%0d ovf=%0b",
                         i, o.idx, o.per, o.hi, o.ovf, exp_q[i].idx, exp_q[i].per, exp_q[i].hi, exp_q[i].ovf);
            end
        end
    endtask

    task automatic test_en_drop();
        int d0, dlen;
        clear_seq();
        add_const(1'b0, 4, 1'b0);
        add_wave(8, 4, 80);
        add_const(1'b0, 5, 1'b0);
        d0   = 40 + $urandom_range(0, 3);
        dlen = $urandom_range(3, 10);
        for (int i = d0; i < d0 + dlen; i++) en_q[i] = 1'b0;
        model_run();
        play();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL en_drop count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t o;
            o = (i < obs_q.size()) ? obs_q[i] : ev_t'(0);
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL en_drop strobe %0d: got idx=%0d per=%0d hi=%0d ovf=%0b, expected idx=%0d per=%0d hi=%0d ovf=%0b",
                         i, o.idx, o.per, o.hi, o.ovf, exp_q[i].idx, exp_q[i].per, exp_q[i].hi, exp_q[i].ovf);
            end
        end
        for (int j = SS + 1; j < arm_obs.size(); j++) begin
            tests++;
            if (arm_obs[j] !== exp_arm[j-SS-1]) begin
                fails++;
                $display("FAIL en_drop armed @%0d: got %b, expected %b", j, arm_obs[j], exp_arm[j-SS-1]);
            end
            if (!exp_arm[j-SS-1] && (j > int'(exp_q[0].idx))) begin
                tests++;
                if (per_obs[j] !== CNT_W'(8)) begin
                    fails++;
                    $display("FAIL en_drop retained @%0d: got period %0d, expected 8", j, per_obs[j]);
                end
            end
        end
    endtask

    task automatic test_random();
        clear_seq();
        add_const(1'b0, 4, 1'b0);
        for (int s = 0; s < 8; s++) begin
            int p, h;
            p = $urandom_range(2, 24);
            h = $urandom_range(1, p - 1);
            add_wave(p, h, p * $urandom_range(2, 4));
            if ($urandom_range(0, 3) == 0) add_const(1'b0, $urandom_range(1, 6), 1'b0);
        end
        add_const(1'b0, 5, 1'b0);
        model_run();
        play();
        tests++;
        if (obs_q.size() != exp_q.size()) begin
            fails++;
            $display("FAIL random count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            ev_t o;
            o = (i < obs_q.size()) ? obs_q[i] : ev_t'(0);
            tests++;
            if (o !== exp_q[i]) begin
                fails++;
                $display("FAIL random strobe %0d: got idx=%0d per=%0d hi=%0d ovf=%0b, expected idx=%0d per=%0d hi=%0d ovf=%0b",
                         i, o.idx, o.per, o.hi, o.ovf, exp_q[i].idx, exp_q[i].per, exp_q[i].hi, exp_q[i].ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wave("div4", 4, 2, $urandom_range(6, 10));
        test_wave("asym", 10, 3, 6);
        test_saturate();
        test_en_drop();
        test_wave("fastest", 2, 1, 15);
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
